// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state, read owner, streak width.
package dm_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRdWait
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnCpu,
        OwnLd
    } owner_e;

    localparam int unsigned StreakWidth = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the requesters (CPU, host loader), the data memory and the arbiter.
// slave: arbiter side. master: requesters plus the memory's read-data return.
interface dm_arbiter_if #(
    parameter int unsigned reg_width  = 12,
    parameter int unsigned addr_width = 8
) ();

    // CPU port
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [addr_width-1:0] cpu_addr;
    logic [reg_width-1:0]  cpu_wdata;
    logic                  cpu_wait;
    logic                  cpu_rvalid;
    logic [reg_width-1:0]  cpu_rdata;

    // Host loader port
    logic                  ld_req;
    logic                  ld_we;
    logic [addr_width-1:0] ld_addr;
    logic [reg_width-1:0]  ld_wdata;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [reg_width-1:0]  ld_rdata;

    // Data memory port
    logic [addr_width-1:0] mem_address;
    logic [reg_width-1:0]  mem_data;
    logic                  mem_wren;
    logic [reg_width-1:0]  mem_q;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_wait, cpu_rvalid, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_wait, cpu_rvalid, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: one access per cycle, CPU priority, loader forced through after
// starve_limit consecutive contested CPU grants, one outstanding read tracked.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned reg_width    = 12,
    parameter int unsigned addr_width   = 8,
    parameter int unsigned starve_limit = 4
) (
    input  logic       clk,
    input  logic       reset,
    dm_arbiter_if.slave bus
);

    localparam logic [StreakWidth-1:0] StreakLimit = StreakWidth'(starve_limit);

    arb_state_e              state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [StreakWidth-1:0]  streak_q, streak_d;

    logic                    cpu_req;
    logic                    ld_force;
    logic                    cpu_grant;
    logic                    ld_grant;
    logic                    rd_live;
    logic [addr_width-1:0]   addr_mux;
    logic [reg_width-1:0]    data_mux;
    logic                    wren_mux;

    // Grant decision; grants are suppressed while reset is low so nothing reaches memory.
    always_comb begin
        cpu_req   = bus.cpu_rd | bus.cpu_wr;
        ld_force  = bus.ld_req && (streak_q == StreakLimit);
        cpu_grant = reset && (state_q == StIdle) && cpu_req && !ld_force;
        ld_grant  = reset && (state_q == StIdle) && bus.ld_req && !cpu_grant;
    end

    // Memory port mux: grantee drives the port in the grant cycle, otherwise all zero.
    always_comb begin
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
        if (cpu_grant) begin
            addr_mux = bus.cpu_addr;
            data_mux = bus.cpu_wdata;
            wren_mux = bus.cpu_wr; // rd+wr together is a write
        end else if (ld_grant) begin
            addr_mux = bus.ld_addr;
            data_mux = bus.ld_wdata;
            wren_mux = bus.ld_we;
        end
    end

    // Handshake and memory outputs.
    always_comb begin
        bus.mem_address = addr_mux;
        bus.mem_data    = data_mux;
        bus.mem_wren    = wren_mux;
        bus.cpu_wait    = cpu_req && !cpu_grant;
        bus.ld_gnt      = ld_grant;
    end

    // Read return: only the owner sees rvalid/data; a read cut by reset returns nothing.
    always_comb begin
        rd_live        = reset && (state_q == StRdWait);
        bus.cpu_rvalid = rd_live && (owner_q == OwnCpu);
        bus.ld_rvalid  = rd_live && (owner_q == OwnLd);
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_q : '0;
        bus.ld_rdata   = bus.ld_rvalid ? bus.mem_q : '0;
    end

    // Next-state: FSM, read owner and loader starvation streak.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_grant && !bus.cpu_wr) begin
                    state_d = StRdWait;
                    owner_d = OwnCpu;
                end else if (ld_grant && !bus.ld_we) begin
                    state_d = StRdWait;
                    owner_d = OwnLd;
                end
            end
            StRdWait: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase

        if (!bus.ld_req || ld_grant) begin
            streak_d = '0;
        end else if (cpu_grant && (streak_q != StreakLimit)) begin
            streak_d = streak_q + StreakWidth'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            owner_q  <= OwnNone;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: per-cycle vector table plus hand-written reset and
// starvation sequences. A behavioural 1-cycle-latency memory sits on the memory port.
module tb_dm_arbiter;

    typedef struct packed {
        logic        cpu_wait;
        logic        cpu_rvalid;
        logic [11:0] cpu_rdata;
        logic        ld_gnt;
        logic        ld_rvalid;
        logic [11:0] ld_rdata;
        logic        mem_wren;
        logic [7:0]  mem_address;
        logic [11:0] mem_data;
    } out_t;

    typedef struct {
        logic        rst_n;
        logic        cpu_rd;
        logic        cpu_wr;
        logic [7:0]  cpu_addr;
        logic [11:0] cpu_wdata;
        logic        ld_req;
        logic        ld_we;
        logic [7:0]  ld_addr;
        logic [11:0] ld_wdata;
        out_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [11:0] mem [256];

    int n_vec  = 0;
    int n_miss = 0;

    dm_arbiter_if #(.reg_width(12), .addr_width(8)) bus ();

    dm_arbiter #(
        .reg_width   (12),
        .addr_width  (8),
        .starve_limit(4)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory, cleared while the bench holds reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.mem_wren) begin
            mem[bus.mem_address] <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_address];
    end

    function automatic out_t eo(input logic wt, input logic crv, input logic [11:0] crd,
                                input logic gnt, input logic lrv, input logic [11:0] lrd,
                                input logic wren, input logic [7:0] addr,
                                input logic [11:0] data);
        out_t o;
        o.cpu_wait    = wt;
        o.cpu_rvalid  = crv;
        o.cpu_rdata   = crd;
        o.ld_gnt      = gnt;
        o.ld_rvalid   = lrv;
        o.ld_rdata    = lrd;
        o.mem_wren    = wren;
        o.mem_address = addr;
        o.mem_data    = data;
        return o;
    endfunction

    function automatic vec_t mk(input logic rst, input logic crd, input logic cwr,
                                input logic [7:0] caddr, input logic [11:0] cwd,
                                input logic lreq, input logic lwe, input logic [7:0] laddr,
                                input logic [11:0] lwd, input out_t exp);
        vec_t v;
        v.rst_n     = rst;
        v.cpu_rd    = crd;
        v.cpu_wr    = cwr;
        v.cpu_addr  = caddr;
        v.cpu_wdata = cwd;
        v.ld_req    = lreq;
        v.ld_we     = lwe;
        v.ld_addr   = laddr;
        v.ld_wdata  = lwd;
        v.exp       = exp;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, sample outputs 1 ns later.
    task automatic apply(input vec_t v, input string name);
        out_t act;
        @(negedge clk);
        rst_n         = v.rst_n;
        bus.cpu_rd    = v.cpu_rd;
        bus.cpu_wr    = v.cpu_wr;
        bus.cpu_addr  = v.cpu_addr;
        bus.cpu_wdata = v.cpu_wdata;
        bus.ld_req    = v.ld_req;
        bus.ld_we     = v.ld_we;
        bus.ld_addr   = v.ld_addr;
        bus.ld_wdata  = v.ld_wdata;
        #1;
        act.cpu_wait    = bus.cpu_wait;
        act.cpu_rvalid  = bus.cpu_rvalid;
        act.cpu_rdata   = bus.cpu_rdata;
        act.ld_gnt      = bus.ld_gnt;
        act.ld_rvalid   = bus.ld_rvalid;
        act.ld_rdata    = bus.ld_rdata;
        act.mem_wren    = bus.mem_wren;
        act.mem_address = bus.mem_address;
        act.mem_data    = bus.mem_data;
        n_vec++;
        if (act !== v.exp) begin
            n_miss++;
            $display("FAIL %s: got wait=%b crv=%b crd=%h gnt=%b lrv=%b lrd=%h wren=%b addr=%h data=%h, want wait=%b crv=%b crd=%h gnt=%b lrv=%b lrd=%h wren=%b addr=%h data=%h",
                     name, act.cpu_wait, act.cpu_rvalid, act.cpu_rdata, act.ld_gnt,
                     act.ld_rvalid, act.ld_rdata, act.mem_wren, act.mem_address,
                     act.mem_data, v.exp.cpu_wait, v.exp.cpu_rvalid, v.exp.cpu_rdata,
                     v.exp.ld_gnt, v.exp.ld_rvalid, v.exp.ld_rdata, v.exp.mem_wren,
                     v.exp.mem_address, v.exp.mem_data);
        end
    endtask

    vec_t  tbl[$];
    out_t  z;
    out_t  e;

    initial begin
        z = eo(0, 0, 12'h0, 0, 0, 12'h0, 0, 8'h00, 12'h0);

        rst_n         = 1'b0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ld_req    = 1'b0;
        bus.ld_we     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_wdata  = '0;

        // Reset cut into a CPU read's RD_WAIT: no rvalid, outputs quiet, IDLE afterwards.
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0, z), "rst_hold");
        apply(mk(1, 1, 0, 8'h05, 12'h0, 0, 0, 8'h00, 12'h0,
                 eo(0, 0, 12'h0, 0, 0, 12'h0, 0, 8'h05, 12'h0)), "rst_cpu_rd_acc");
        apply(mk(0, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0, z), "rst_in_rdwait");
        apply(mk(0, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0, z), "rst_second");
        apply(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0, z), "rst_no_late_rvalid");
        apply(mk(1, 0, 0, 8'h00, 12'h0, 1, 0, 8'h40, 12'h0,
                 eo(0, 0, 12'h0, 1, 0, 12'h0, 0, 8'h40, 12'h0)), "rst_idle_grant");
        apply(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0,
                 eo(0, 0, 12'h0, 0, 1, 12'h0, 0, 8'h00, 12'h0)), "rst_ld_rvalid");

        // CPU write then read back
        tbl.push_back(mk(1, 0, 1, 8'h05, 12'hABC, 0, 0, 8'h00, 12'h0,
                         eo(0, 0, 12'h0, 0, 0, 12'h0, 1, 8'h05, 12'hABC)));
        tbl.push_back(mk(1, 1, 0, 8'h05, 12'h0, 0, 0, 8'h00, 12'h0,
                         eo(0, 0, 12'h0, 0, 0, 12'h0, 0, 8'h05, 12'h0)));
        tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0,
                         eo(0, 1, 12'hABC, 0, 0, 12'h0, 0, 8'h00, 12'h0)));
        // Loader back-to-back writes 0x10..0x13
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 1, 1, 8'(8'h10 + i), 12'(i + 1),
                             eo(0, 0, 12'h0, 1, 0, 12'h0, 1, 8'(8'h10 + i), 12'(i + 1))));
        // Loader reads, each 2 cycles apart; next address requested during RD_WAIT
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 1, 0, 8'(8'h10 + i), 12'h0,
                             eo(0, 0, 12'h0, 1, 0, 12'h0, 0, 8'(8'h10 + i), 12'h0)));
            tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, (i < 3), 0,
                             (i < 3) ? 8'(8'h11 + i) : 8'h00, 12'h0,
                             eo(0, 0, 12'h0, 0, 1, 12'(i + 1), 0, 8'h00, 12'h0)));
        end
        // Contention: CPU read wins, loader goes after CPU rvalid
        tbl.push_back(mk(1, 1, 0, 8'h20, 12'h0, 1, 0, 8'h30, 12'h0,
                         eo(0, 0, 12'h0, 0, 0, 12'h0, 0, 8'h20, 12'h0)));
        tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 1, 0, 8'h30, 12'h0,
                         eo(0, 1, 12'h0, 0, 0, 12'h0, 0, 8'h00, 12'h0)));
        tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 1, 0, 8'h30, 12'h0,
                         eo(0, 0, 12'h0, 1, 0, 12'h0, 0, 8'h30, 12'h0)));
        tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0,
                         eo(0, 0, 12'h0, 0, 1, 12'h0, 0, 8'h00, 12'h0)));
        // rd+wr together is a write; then read back with request held into RD_WAIT
        tbl.push_back(mk(1, 1, 1, 8'h07, 12'h5A5, 0, 0, 8'h00, 12'h0,
                         eo(0, 0, 12'h0, 0, 0, 12'h0, 1, 8'h07, 12'h5A5)));
        tbl.push_back(mk(1, 1, 0, 8'h07, 12'h0, 0, 0, 8'h00, 12'h0,
                         eo(0, 0, 12'h0, 0, 0, 12'h0, 0, 8'h07, 12'h0)));
        tbl.push_back(mk(1, 1, 0, 8'h07, 12'h0, 0, 0, 8'h00, 12'h0,
                         eo(1, 1, 12'h5A5, 0, 0, 12'h0, 0, 8'h00, 12'h0)));
        tbl.push_back(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0, z));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Starvation: continuous CPU writes vs held loader write; every 5th cycle is loader's.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                e = eo(1, 0, 12'h0, 1, 0, 12'h0, 1, 8'h60, 12'h777);
            else
                e = eo(0, 0, 12'h0, 0, 0, 12'h0, 1, 8'(8'h50 + i), 12'(i));
            apply(mk(1, 0, 1, 8'(8'h50 + i), 12'(i), 1, 1, 8'h60, 12'h777, e),
                  $sformatf("starve%0d", i));
        end
        apply(mk(1, 1, 0, 8'h53, 12'h0, 0, 0, 8'h00, 12'h0,
                 eo(0, 0, 12'h0, 0, 0, 12'h0, 0, 8'h53, 12'h0)), "starve_rd_cpu");
        apply(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0,
                 eo(0, 1, 12'h003, 0, 0, 12'h0, 0, 8'h00, 12'h0)), "starve_cpu_data");
        apply(mk(1, 0, 0, 8'h00, 12'h0, 1, 0, 8'h60, 12'h0,
                 eo(0, 0, 12'h0, 1, 0, 12'h0, 0, 8'h60, 12'h0)), "starve_rd_ld");
        apply(mk(1, 0, 0, 8'h00, 12'h0, 0, 0, 8'h00, 12'h0,
                 eo(0, 0, 12'h0, 0, 1, 12'h777, 0, 8'h00, 12'h0)), "starve_ld_data");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
